// File: rtl/alu_serie_ctrl_if.sv
// rtl/alu_serie_ctrl_if.sv - host command/result bundle for the bit-serial ALU sequencer
interface alu_serie_ctrl_if #(
  parameter int ANCHO = 8
);
  logic             inicio;
  logic [2:0]       op;
  logic [ANCHO-1:0] a;
  logic [ANCHO-1:0] b;
  logic             ocupado;
  logic             listo;
  logic [ANCHO-1:0] resultado;
  logic             acarreo;

  modport master (
    output inicio, op, a, b,
    input  ocupado, listo, resultado, acarreo
  );

  modport slave (
    input  inicio, op, a, b,
    output ocupado, listo, resultado, acarreo
  );
endinterface

// File: rtl/alu_serie_ctrl.sv
// rtl/alu_serie_ctrl.sv - LSB-first bit-serial sequencer for a 1-bit ALU (optional flags: ALU_SERIE_BANDERAS_EN)
module alu_serie_ctrl #(
  parameter int ANCHO = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_serie_ctrl_if.slave  host,
  output logic             alu_numero1,
  output logic             alu_numero2,
  output logic [2:0]       alu_codigo,
  output logic             alu_in,
  input  logic             alu_salida
`ifdef ALU_SERIE_BANDERAS_EN
  ,
  output logic             cero,
  output logic             desborde
`endif
);

  localparam int CW = $clog2(ANCHO);
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_NOT = 3'b110;

  typedef enum logic [1:0] {REPOSO, CALCULO, FIN} estado_t;

  estado_t          state_q, state_d;
  logic [ANCHO-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [ANCHO-1:0] resultado_q, resultado_d, res_sig;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d, carry_sig;
  logic             acarreo_q, acarreo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef ALU_SERIE_BANDERAS_EN
  logic             cero_q, cero_d, desborde_q, desborde_d;
`endif

  function automatic logic op_valida(input logic [2:0] o);
    return (o == OP_ADD) || (o == OP_SUB) || (o == OP_OR) ||
           (o == OP_AND) || (o == OP_NOT);
  endfunction

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    res_d       = res_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    resultado_d = resultado_q;
    acarreo_d   = acarreo_q;
`ifdef ALU_SERIE_BANDERAS_EN
    cero_d      = cero_q;
    desborde_d  = desborde_q;
`endif
    res_sig      = {alu_salida, res_q[ANCHO-1:1]};
    carry_sig    = 1'b0;
    alu_numero1  = 1'b0;
    alu_numero2  = 1'b0;
    alu_codigo   = 3'b000;
    alu_in       = 1'b0;
    host.ocupado = 1'b0;
    host.listo   = 1'b0;

    case (state_q)
      REPOSO: begin
        if (host.inicio) begin
          if (op_valida(host.op)) begin
            a_d     = host.a;
            b_d     = host.b;
            op_d    = host.op;
            res_d   = '0;
            carry_d = 1'b0;
            cnt_d   = '0;
            state_d = CALCULO;
          end else begin
            resultado_d = '0;
            acarreo_d   = 1'b0;
`ifdef ALU_SERIE_BANDERAS_EN
            cero_d      = 1'b1;
            desborde_d  = 1'b0;
`endif
            state_d     = FIN;
          end
        end
      end
      CALCULO: begin
        host.ocupado = 1'b1;
        alu_numero1  = a_q[0];
        alu_numero2  = b_q[0];
        alu_codigo   = op_q;
        alu_in       = carry_q;
        // The ALU has no carry-out, so carry/borrow is regenerated here from the same bits.
        case (op_q)
          OP_ADD:  carry_sig = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
          OP_SUB:  carry_sig = (~a_q[0] & b_q[0]) | (carry_q & ~(a_q[0] ^ b_q[0]));
          default: carry_sig = 1'b0;
        endcase
        carry_d = carry_sig;
        res_d   = res_sig;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(ANCHO - 1)) begin
          resultado_d = res_sig;
          acarreo_d   = carry_sig;
`ifdef ALU_SERIE_BANDERAS_EN
          cero_d      = (res_sig == '0);
          desborde_d  = ((op_q == OP_ADD) || (op_q == OP_SUB)) ? (carry_q ^ carry_sig) : 1'b0;
`endif
          state_d     = FIN;
        end
      end
      FIN: begin
        host.listo = 1'b1;
        state_d    = REPOSO;
      end
      default: state_d = REPOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= REPOSO;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      resultado_q <= '0;
      acarreo_q   <= 1'b0;
`ifdef ALU_SERIE_BANDERAS_EN
      cero_q      <= 1'b0;
      desborde_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      resultado_q <= resultado_d;
      acarreo_q   <= acarreo_d;
`ifdef ALU_SERIE_BANDERAS_EN
      cero_q      <= cero_d;
      desborde_q  <= desborde_d;
`endif
    end
  end

  assign host.resultado = resultado_q;
  assign host.acarreo   = acarreo_q;
`ifdef ALU_SERIE_BANDERAS_EN
  assign cero     = cero_q;
  assign desborde = desborde_q;
`endif

endmodule
